// File: rtl/spi_ram_burst.sv
// Command-decoded single-port RAM behind the SPI slave: address/data
// commands with independent write/read pointers, optional burst
// auto-increment, configurable read latency and optional clear after reset.
module spi_ram_burst #(
   parameter int unsigned DATA_W         = 8,
   parameter int unsigned ADDR_W         = 8,
   parameter int unsigned AUTO_INC       = 1,
   parameter int unsigned RD_LAT         = 1,
   parameter int unsigned CLEAR_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W+1:0] din,
   input  logic              rx_valid,
   output logic [DATA_W-1:0] dout,
   output logic              tx_valid,
   output logic              ready,
   output logic              err
);

   localparam int unsigned MEM_DEPTH = 2 ** ADDR_W;

   localparam logic [1:0] CMD_WR_ADDR = 2'd0;
   localparam logic [1:0] CMD_WR_DATA = 2'd1;
   localparam logic [1:0] CMD_RD_ADDR = 2'd2;
   localparam logic [1:0] CMD_RD_DATA = 2'd3;

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   localparam state_t ST_RST = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
   logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
   logic [ADDR_W-1:0] rd_ptr, rd_ptr_nxt;

   logic [1:0]        cmd_c;
   logic [DATA_W-1:0] payload_c;
   logic              mem_we_c;
   logic [ADDR_W-1:0] mem_addr_c;
   logic [DATA_W-1:0] mem_wdata_c;
   logic              rd_issue_c;

   logic [DATA_W-1:0] mem [MEM_DEPTH];

   logic              s1_v;
   logic [DATA_W-1:0] s1_d;
   logic              last_v_c;
   logic [DATA_W-1:0] last_d_c;

   assign cmd_c     = din[DATA_W+1:DATA_W];
   assign payload_c = din[DATA_W-1:0];

   // State, pointers and handshake registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_RST;
         clr_cnt <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         ready   <= 1'(CLEAR_ON_RESET == 0);
         err     <= 1'b0;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_cnt_nxt;
         wr_ptr  <= wr_ptr_nxt;
         rd_ptr  <= rd_ptr_nxt;
         ready   <= (state_nxt == ST_RUN);
         err     <= rx_valid && !ready;
      end
   end

   // Next state: sweep the clear counter, or decode an accepted command
   always_comb begin
      state_nxt   = state;
      clr_cnt_nxt = clr_cnt;
      wr_ptr_nxt  = wr_ptr;
      rd_ptr_nxt  = rd_ptr;
      mem_we_c    = 1'b0;
      mem_addr_c  = wr_ptr;
      mem_wdata_c = payload_c;
      rd_issue_c  = 1'b0;
      case (state)
         ST_CLEAR: begin
            mem_we_c    = 1'b1;
            mem_addr_c  = clr_cnt;
            mem_wdata_c = '0;
            clr_cnt_nxt = ADDR_W'(clr_cnt + 1'b1);
            if (clr_cnt == ADDR_W'(MEM_DEPTH - 1)) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (rx_valid && ready) begin
               case (cmd_c)
                  CMD_WR_ADDR: wr_ptr_nxt = payload_c[ADDR_W-1:0];
                  CMD_WR_DATA: begin
                     mem_we_c = 1'b1;
                     if (AUTO_INC != 0) wr_ptr_nxt = ADDR_W'(wr_ptr + 1'b1);
                  end
                  CMD_RD_ADDR: rd_ptr_nxt = payload_c[ADDR_W-1:0];
                  CMD_RD_DATA: begin
                     rd_issue_c = 1'b1;
                     if (AUTO_INC != 0) rd_ptr_nxt = ADDR_W'(rd_ptr + 1'b1);
                  end
               endcase
            end
         end
      endcase
      // Memory must not change while reset is held, whatever the inputs do
      if (rst) mem_we_c = 1'b0;
   end

   // Memory array (no reset; contents survive rst)
   always_ff @(posedge clk) begin
      if (mem_we_c) mem[mem_addr_c] <= mem_wdata_c;
   end

   // First read stage: capture the addressed word when a read issues
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v <= 1'b0;
         s1_d <= '0;
      end else begin
         s1_v <= rd_issue_c;
         s1_d <= mem[rd_ptr];
      end
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic              s2_v;
         logic [DATA_W-1:0] s2_d;

         // Extra read stage for two-cycle latency
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               s2_v <= 1'b0;
               s2_d <= '0;
            end else begin
               s2_v <= s1_v;
               s2_d <= s1_d;
            end
         end

         assign last_v_c = s2_v;
         assign last_d_c = s2_d;
      end else begin : g_lat1
         assign last_v_c = s1_v;
         assign last_d_c = s1_d;
      end
   endgenerate

   // Output register: dout holds its last value between reads
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout     <= '0;
         tx_valid <= 1'b0;
      end else begin
         tx_valid <= last_v_c;
         if (last_v_c) dout <= last_d_c;
      end
   end

endmodule

// File: tb/tb_spi_ram_burst.sv
// Bench for spi_ram_burst: three configurations share one command stream
// and are compared every cycle against a schedule-based behavioural model.
module tb_spi_ram_burst;

   logic       clk;
   logic       rst;
   logic [9:0] din;
   logic       rx_valid;
   logic [7:0] dout     [3];
   logic       tx_valid [3];
   logic       ready    [3];
   logic       err      [3];

   int n_chk;
   int n_pass;
   int zc;

   // Per-instance configuration: A default, B two-cycle latency, C no auto-inc
   int unsigned cfg_lat [3] = '{1, 2, 1};
   int unsigned cfg_inc [3] = '{1, 1, 0};
   int unsigned cfg_clr [3] = '{1, 0, 0};

   // Behavioural model state
   logic [7:0] m_mem  [3][256];
   int         m_clr_left [3];
   logic [7:0] m_wp   [3];
   logic [7:0] m_rp   [3];
   logic [7:0] m_dout [3];
   logic       m_tx   [3];
   logic       m_err  [3];
   logic       m_sv   [3][8];
   logic [7:0] m_sd   [3][8];
   int         edge_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .AUTO_INC(1), .RD_LAT(1), .CLEAR_ON_RESET(1)) u_a (
      .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid),
      .dout(dout[0]), .tx_valid(tx_valid[0]), .ready(ready[0]), .err(err[0]));

   spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .AUTO_INC(1), .RD_LAT(2), .CLEAR_ON_RESET(0)) u_b (
      .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid),
      .dout(dout[1]), .tx_valid(tx_valid[1]), .ready(ready[1]), .err(err[1]));

   spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .AUTO_INC(0), .RD_LAT(1), .CLEAR_ON_RESET(0)) u_c (
      .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid),
      .dout(dout[2]), .tx_valid(tx_valid[2]), .ready(ready[2]), .err(err[2]));

   task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_clr_left[i] = (cfg_clr[i] != 0) ? 256 : 0;
         m_wp[i]   = 8'h00;
         m_rp[i]   = 8'h00;
         m_dout[i] = 8'h00;
         m_tx[i]   = 1'b0;
         m_err[i]  = 1'b0;
         for (int s = 0; s < 8; s++) m_sv[i][s] = 1'b0;
      end
   endtask

   // One clock edge of the reference: reads are scheduled lat edges ahead
   task automatic model_edge();
      logic       rdy;
      logic [1:0] cmd;
      logic [7:0] pl;
      int         slot;
      if (rst) return;
      edge_n++;
      cmd = din[9:8];
      pl  = din[7:0];
      for (int i = 0; i < 3; i++) begin
         rdy      = (m_clr_left[i] == 0);
         m_err[i] = rx_valid && !rdy;
         m_tx[i]  = 1'b0;
         slot     = edge_n % 8;
         if (m_sv[i][slot]) begin
            m_tx[i]   = 1'b1;
            m_dout[i] = m_sd[i][slot];
            m_sv[i][slot] = 1'b0;
         end
         if (!rdy) begin
            m_mem[i][256 - m_clr_left[i]] = 8'h00;
            m_clr_left[i]--;
         end else if (rx_valid) begin
            case (cmd)
               2'd0: m_wp[i] = pl;
               2'd1: begin
                  m_mem[i][m_wp[i]] = pl;
                  if (cfg_inc[i] != 0) m_wp[i] = m_wp[i] + 8'd1;
               end
               2'd2: m_rp[i] = pl;
               default: begin
                  slot = (edge_n + int'(cfg_lat[i])) % 8;
                  m_sv[i][slot] = 1'b1;
                  m_sd[i][slot] = m_mem[i][m_rp[i]];
                  if (cfg_inc[i] != 0) m_rp[i] = m_rp[i] + 8'd1;
               end
            endcase
         end
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 3; i++) begin
         chk("tx_valid", i, 32'(tx_valid[i]), 32'(m_tx[i]));
         chk("dout",     i, 32'(dout[i]),     32'(m_dout[i]));
         chk("ready",    i, 32'(ready[i]),    32'(m_clr_left[i] == 0));
         chk("err",      i, 32'(err[i]),      32'(m_err[i]));
      end
   endtask

   // Drive one cycle of input, advance the model, check after the edge
   task automatic step(input logic v, input logic [1:0] c, input logic [7:0] p);
      rx_valid = v;
      din      = {c, p};
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   // Asynchronous reset: outputs must clear without waiting for a clock
   task automatic do_reset(input int cycles);
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      repeat (cycles) step(1'b1, 2'd1, 8'hEE);
      rst = 1'b0;
      rx_valid = 1'b0;
   endtask

   initial begin
      n_chk = 0; n_pass = 0; edge_n = 0; zc = 0;
      rst = 1'b1; rx_valid = 1'b0; din = '0;
      for (int i = 0; i < 3; i++)
         for (int a = 0; a < 256; a++) m_mem[i][a] = 8'h00;
      model_reset();
      @(negedge clk);
      do_reset(3);

      // Clear window of A; zero-fill B and C (A drops these with err)
      #1;
      if (ready[0] == 1'b0) zc = 1;
      for (int a = 0; a < 256; a++) begin
         step(1'b1, 2'd0, 8'(a));
         if (ready[0] == 1'b0) zc++;
         step(1'b1, 2'd1, 8'h00);
         if (ready[0] == 1'b0) zc++;
      end
      chk("clear_len", 0, 32'(zc), 32'd256);

      // Read back cleared words
      step(1'b1, 2'd2, 8'h00);
      repeat (4) step(1'b1, 2'd3, 8'h00);
      repeat (3) step(1'b0, 2'd0, 8'h00);

      // Write burst across the wrap point, then read it back-to-back
      step(1'b1, 2'd0, 8'hFE);
      step(1'b1, 2'd1, 8'h11);
      step(1'b1, 2'd1, 8'h22);
      step(1'b1, 2'd1, 8'h33);
      step(1'b1, 2'd2, 8'hFE);
      repeat (3) step(1'b1, 2'd3, 8'h00);
      repeat (3) step(1'b0, 2'd3, 8'h00);

      // Latency check plus read directly after write
      step(1'b1, 2'd0, 8'h10);
      step(1'b1, 2'd1, 8'hA5);
      step(1'b1, 2'd2, 8'h10);
      step(1'b1, 2'd3, 8'h00);
      repeat (3) step(1'b0, 2'd3, 8'h00);
      step(1'b1, 2'd2, 8'h10);
      step(1'b1, 2'd0, 8'h10);
      step(1'b1, 2'd1, 8'h5A);
      step(1'b1, 2'd3, 8'h00);
      repeat (3) step(1'b0, 2'd0, 8'h00);

      // Held command without rx_valid has no effect
      repeat (5) step(1'b0, 2'd1, 8'h77);
      step(1'b1, 2'd2, 8'h12);
      repeat (2) step(1'b1, 2'd3, 8'h00);
      repeat (3) step(1'b0, 2'd0, 8'h00);

      // Pointer independence
      step(1'b1, 2'd2, 8'h80);
      step(1'b1, 2'd0, 8'h40);
      step(1'b1, 2'd1, 8'h9C);
      step(1'b1, 2'd3, 8'h00);
      step(1'b1, 2'd0, 8'h80);
      step(1'b1, 2'd1, 8'h3E);
      step(1'b1, 2'd2, 8'h40);
      step(1'b1, 2'd3, 8'h00);
      repeat (3) step(1'b0, 2'd0, 8'h00);

      // Rewrite same address (held pointer in C), neighbour untouched
      step(1'b1, 2'd0, 8'h05);
      step(1'b1, 2'd1, 8'h01);
      step(1'b1, 2'd1, 8'h02);
      step(1'b1, 2'd2, 8'h05);
      repeat (2) step(1'b1, 2'd3, 8'h00);
      step(1'b1, 2'd2, 8'h06);
      step(1'b1, 2'd3, 8'h00);
      repeat (3) step(1'b0, 2'd0, 8'h00);

      // Random command traffic
      for (int n = 0; n < 600; n++)
         step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom));
      repeat (3) step(1'b0, 2'd0, 8'h00);

      // Reset during outstanding reads
      step(1'b1, 2'd0, 8'h20);
      step(1'b1, 2'd1, 8'hC3);
      step(1'b1, 2'd2, 8'h20);
      step(1'b1, 2'd3, 8'h00);
      step(1'b1, 2'd3, 8'h00);
      do_reset(2);
      step(1'b1, 2'd1, 8'h55);
      repeat (260) step(1'b0, 2'd0, 8'h00);
      step(1'b1, 2'd2, 8'h00);
      repeat (2) step(1'b1, 2'd3, 8'h00);
      repeat (3) step(1'b0, 2'd0, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/spi_ram_burst.md
Name: spi_ram_burst

Overview:
Parametrised command-decoded single-port RAM behind the SPI slave. It consumes {cmd[1:0], payload} words from the SPI receive path and returns read data on the transmit path. Over the 256x8 fixed-function RAM it adds:
- generic data and address widths;
- separate write and read address pointers with optional auto-increment for burst transfers;
- configurable read latency;
- optional memory clear after reset, with a ready/err handshake.

Parameters:
DATA_W, 8, payload and memory word width
ADDR_W, 8, address width; MEM_DEPTH = 2**ADDR_W; must satisfy ADDR_W <= DATA_W
AUTO_INC, 1, 1 = pointer post-increments after each data command; 0 = pointer holds
RD_LAT, 1, read latency in cycles; legal values 1 or 2
CLEAR_ON_RESET, 1, 1 = zero every memory word after reset before accepting commands

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
din  input  DATA_W+2  din[DATA_W+1:DATA_W] = cmd, din[DATA_W-1:0] = payload
rx_valid  input  1  din valid this cycle; command accepted when rx_valid && ready
dout  output  DATA_W  read data, registered
tx_valid  output  1  dout valid, one-cycle pulse per accepted read
ready  output  1  block accepting commands
err  output  1  one-cycle pulse: rx_valid asserted while ready=0 (command dropped)

Behaviour:
- Reset (asynchronous, rst=1):
  - dout=0, tx_valid=0, err=0; wr_ptr=0, rd_ptr=0; read pipeline flushed.
  - ready=0 if CLEAR_ON_RESET=1, else ready=1.
  - Memory contents are untouched by rst itself.
- FSM states CLEAR and RUN. Reset enters CLEAR if CLEAR_ON_RESET=1, else RUN.
- CLEAR state:
  - clr_cnt starts at 0; each cycle writes 0 to mem[clr_cnt] and increments clr_cnt.
  - After writing MEM_DEPTH-1, go to RUN. ready rises the cycle after that final write; CLEAR lasts exactly MEM_DEPTH cycles.
  - rst asserted during CLEAR restarts it from address 0.
- RUN state: ready=1. An accepted command is decoded by cmd:
  - 00 WR_ADDR: wr_ptr <= payload[ADDR_W-1:0]. Upper payload bits are ignored.
  - 01 WR_DATA: mem[wr_ptr] <= payload. If AUTO_INC, wr_ptr <= wr_ptr+1.
  - 10 RD_ADDR: rd_ptr <= payload[ADDR_W-1:0].
  - 11 RD_DATA: issues a read of mem[rd_ptr]. If AUTO_INC, rd_ptr <= rd_ptr+1.
- rx_valid=0: no state change at all. A held din does not re-trigger a command.
- Pointer wrap: increment is modulo MEM_DEPTH (MEM_DEPTH-1 -> 0). There is no error on wrap.
- Read latency:
  - RD_DATA accepted on edge N gives dout/tx_valid valid after edge N+RD_LAT-1+1. RD_LAT=1 means valid the cycle after acceptance; RD_LAT=2 adds one more register stage.
  - tx_valid is high for exactly one cycle per accepted RD_DATA. Back-to-back RD_DATA commands give tx_valid continuously high, with one new word per cycle in issue order.
  - dout holds its last value while tx_valid=0.
- Read-after-write: WR_DATA on edge N to address A, then RD_DATA of A accepted on edge N+1, returns the new data.
- Independence: write and read pointers are independent; WR_ADDR never changes rd_ptr and vice versa.
- err: asserted for one cycle following any edge where rx_valid=1 and ready=0. The dropped command has no effect.
- Reset mid-read: pending reads are discarded and no tx_valid is produced after reset release.

Test Plan:
1. Clear and ready (DATA_W=8, ADDR_W=8, CLEAR_ON_RESET=1) -> ready=0 for exactly 256 cycles after rst release, then 1. Later RD_ADDR 0x00 followed by 4x RD_DATA -> four tx_valid pulses, dout=0x00 each.
2. Write then read burst:
   - Stimulus: WR_ADDR 0xFE, WR_DATA 0x11, 0x22, 0x33 (AUTO_INC=1); then RD_ADDR 0xFE and 3 back-to-back RD_DATA.
   - Response: mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33 (wrap). tx_valid high 3 consecutive cycles with dout 0x11, 0x22, 0x33.
3. Latency check (RD_LAT=2): WR_ADDR 0x10, WR_DATA 0xA5, RD_ADDR 0x10, then RD_DATA accepted on edge N -> tx_valid=1 and dout=0xA5 only after edge N+2, low otherwise.
4. Handshake and pointers:
   - Send WR_DATA with rx_valid=0 for 5 cycles -> memory and pointers unchanged, tx_valid=0.
   - During CLEAR, assert rx_valid with WR_DATA 0x55 -> err pulses 1 cycle, write dropped.
   - Interleave WR_ADDR 0x40 and RD_ADDR 0x80 -> rd_ptr unaffected by WR_ADDR.
5. AUTO_INC=0: WR_ADDR 0x05, WR_DATA 0x01 then 0x02 -> mem[0x05]=0x02, mem[0x06] unchanged. RD_ADDR 0x05 plus 2x RD_DATA -> dout 0x02 twice.
6. Reset mid-operation: issue 3 RD_DATA, assert rst on the cycle after the first -> dout=0 and tx_valid=0 immediately (asynchronously), no tx_valid after release, CLEAR restarts from 0.
